code_loader: RTL and testbench

- Writer side of the CPU's code-ROM interface: receives a WebAssembly bytecode image over a byte stream and writes it into code memory.
- Holds the CPU in reset until the image is complete, then releases it.
- Input framing: 4-byte magic `00 61 73 6D`, then a 32-bit little-endian payload length, then the payload bytes.
- Sits between the host/UART byte source and the CPU code memory write port.

---
 rtl/code_loader.sv | 170 +++++++++++++++++
 tb/tb_code_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_loader.sv
// Code-ROM loader: parses a magic/length framed byte stream, writes the payload
// into code memory and releases the CPU from reset once the image is in place.
module code_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 4,
  parameter int CAPACITY   = 65532
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  restart,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic [1:0]            error,
  output logic [31:0]           loaded_len,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_MAGIC = 3'd0,
    S_LEN   = 3'd1,
    S_LOAD  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           CAP        = 32'(CAPACITY);
  localparam logic [31:0]           MAGIC_WORD = 32'h6D73_6100;

  state_t      state, next_state;
  logic [1:0]  idx;
  logic [31:0] len_q;
  logic [31:0] remaining;

  logic        accept;
  logic [7:0]  magic_byte;
  logic [31:0] len_full;
  logic        magic_ok;
  logic        len_last;
  logic        ready_next;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready,
  // unless restart is high in that cycle (restart wins and the byte is dropped).
  assign accept     = in_valid && in_ready && !restart;
  assign magic_byte = MAGIC_WORD[{idx, 3'b000} +: 8];
  assign magic_ok   = (in_data == magic_byte);
  assign len_full   = {in_data, len_q[31:8]};
  assign len_last   = (idx == 2'd3);
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_MAGIC;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (restart) begin
      next_state = S_MAGIC;
    end else begin
      case (state)
        S_MAGIC: begin
          if (accept) begin
            if (!magic_ok) begin
              next_state = S_ERROR;
            end else if (len_last) begin
              next_state = S_LEN;
            end
          end
        end
        S_LEN: begin
          if (accept && len_last) begin
            if (len_full > CAP) begin
              next_state = S_ERROR;
            end else if (len_full == 32'd0) begin
              next_state = S_DONE;
            end else begin
              next_state = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept && (remaining == 32'd1)) begin
            next_state = S_DONE;
          end
        end
        default: next_state = state;
      endcase
    end
  end

  assign ready_next = (next_state == S_MAGIC) || (next_state == S_LEN) ||
                      (next_state == S_LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= 2'd0;
      len_q      <= 32'd0;
      remaining  <= 32'd0;
      loaded_len <= 32'd0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_data   <= 8'd0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 2'd0;
    end else if (restart) begin
      idx        <= 2'd0;
      len_q      <= 32'd0;
      remaining  <= 32'd0;
      loaded_len <= 32'd0;
      in_ready   <= ready_next;
      mem_we     <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 2'd0;
    end else begin
      in_ready <= ready_next;
      mem_we   <= 1'b0;
      // done trails DONE entry by one cycle so the final write lands first
      done      <= (state == S_DONE);
      cpu_reset <= (state != S_DONE);
      case (state)
        S_MAGIC: begin
          if (accept) begin
            if (magic_ok) begin
              idx <= idx + 2'd1;
            end else begin
              error <= 2'd1;
            end
          end
        end
        S_LEN: begin
          if (accept) begin
            len_q <= len_full;
            idx   <= idx + 2'd1;
            if (len_last) begin
              remaining <= len_full;
              if (len_full > CAP) begin
                error <= 2'd2;
              end
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            mem_we     <= 1'b1;
            mem_data   <= in_data;
            mem_addr   <= BASE + loaded_len[ADDR_WIDTH-1:0];
            loaded_len <= loaded_len + 32'd1;
            remaining  <= remaining - 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Bench for code_loader: scenario tasks drive framed streams, a negedge monitor
// checks every memory write against an expected {addr,data} queue.
module tb_code_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_reset;
  logic        done;
  logic [1:0]  error;
  logic [31:0] loaded_len;
  logic [2:0]  state_dbg;

  logic [23:0] exp_q[$];
  int          wr_cyc[$];
  int          pass_cnt;
  int          total_cnt;
  int          wr_count;
  int          cyc;

  code_loader #(.ADDR_WIDTH(16), .BASE_ADDR(4), .CAPACITY(65532)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .cpu_reset(cpu_reset), .done(done), .error(error),
    .loaded_len(loaded_len), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && mem_we === 1'b1) begin
      logic [23:0] e;
      wr_count++;
      wr_cyc.push_back(cyc);
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e)
          $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                   mem_addr, mem_data, e[23:8], e[7:0]);
        else
          pass_cnt++;
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL send_timeout: byte %0h not accepted within 20 cycles, required accept", b);
    end
  endtask

  task automatic send_magic(input bit gap);
    send_byte(8'h00, gap);
    send_byte(8'h61, gap);
    send_byte(8'h73, gap);
    send_byte(8'h6D, gap);
  endtask

  task automatic send_len(input logic [31:0] len, input bit gap);
    logic [31:0] l;
    l = len;
    for (int i = 0; i < 4; i++) send_byte(l[i*8 +: 8], gap);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; restart = 1'b0;
    wait_cycles(2);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0h required 0", in_ready); else pass_cnt++;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %0h required 0", mem_we); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'd4) $display("FAIL rst_mem_addr: got %0h required 4", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_data !== 8'd0) $display("FAIL rst_mem_data: got %0h required 0", mem_data); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset: got %0h required 1", cpu_reset); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %0h required 0", done); else pass_cnt++;
    total_cnt++; if (error !== 2'd0) $display("FAIL rst_error: got %0h required 0", error); else pass_cnt++;
    total_cnt++; if (loaded_len !== 32'd0) $display("FAIL rst_loaded_len: got %0h required 0", loaded_len); else pass_cnt++;
    total_cnt++; if (state_dbg !== 3'd0) $display("FAIL rst_state: got %0h required 0", state_dbg); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_release_ready: got %0h required 0", in_ready); else pass_cnt++;
    wait_cycles(1);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_ready_rise: got %0h required 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic_load();
    logic [7:0] pay[3];
    pay = '{8'h41, 8'h2A, 8'h0B};
    wr_cyc.delete();
    send_magic(1'b0);
    send_len(32'd3, 1'b0);
    for (int i = 0; i < 3; i++) exp_q.push_back({16'(4 + i), pay[i]});
    for (int i = 0; i < 3; i++) send_byte(pay[i], 1'b0);
    total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_early: got %0h required 0", done); else pass_cnt++;
    wait_cycles(1);
    total_cnt++; if (done !== 1'b1) $display("FAIL basic_done: got %0h required 1", done); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b0) $display("FAIL basic_cpu_reset: got %0h required 0", cpu_reset); else pass_cnt++;
    total_cnt++; if (loaded_len !== 32'd3) $display("FAIL basic_loaded_len: got %0h required 3", loaded_len); else pass_cnt++;
    total_cnt++; if (error !== 2'd0) $display("FAIL basic_error: got %0h required 0", error); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_ready_done: got %0h required 0", in_ready); else pass_cnt++;
    total_cnt++;
    if (wr_cyc.size() != 3 || wr_cyc[1] - wr_cyc[0] != 1 || wr_cyc[2] - wr_cyc[1] != 1)
      $display("FAIL basic_b2b: got %0d writes, required 3 on consecutive cycles", wr_cyc.size());
    else pass_cnt++;
    // bytes offered while DONE must be ignored
    in_valid = 1'b1; in_data = 8'hEE;
    wait_cycles(3);
    in_valid = 1'b0;
    total_cnt++; if (loaded_len !== 32'd3) $display("FAIL done_ignore: got %0h required 3", loaded_len); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL basic_sb_empty: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_restart_clears();
    pulse_restart();
    total_cnt++; if (state_dbg !== 3'd0) $display("FAIL rs_state: got %0h required 0", state_dbg); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rs_ready: got %0h required 1", in_ready); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rs_done: got %0h required 0", done); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL rs_cpu_reset: got %0h required 1", cpu_reset); else pass_cnt++;
    total_cnt++; if (loaded_len !== 32'd0) $display("FAIL rs_loaded_len: got %0h required 0", loaded_len); else pass_cnt++;
  endtask

  task automatic test_bad_magic();
    int w0;
    w0 = wr_count;
    send_byte(8'h00, 1'b0);
    send_byte(8'h61, 1'b0);
    send_byte(8'h73, 1'b0);
    total_cnt++; if (error !== 2'd0) $display("FAIL bm_no_early_err: got %0h required 0", error); else pass_cnt++;
    send_byte(8'h6E, 1'b0);
    total_cnt++; if (error !== 2'd1) $display("FAIL bm_error: got %0h required 1", error); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bm_ready: got %0h required 0", in_ready); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL bm_cpu_reset: got %0h required 1", cpu_reset); else pass_cnt++;
    total_cnt++; if (state_dbg !== 3'd4) $display("FAIL bm_state: got %0h required 4", state_dbg); else pass_cnt++;
    wait_cycles(3);
    total_cnt++; if (wr_count != w0) $display("FAIL bm_no_write: got %0d writes required 0", wr_count - w0); else pass_cnt++;
    total_cnt++; if (error !== 2'd1 || done !== 1'b0) $display("FAIL bm_hold: got error %0h done %0h required 1/0", error, done); else pass_cnt++;
  endtask

  task automatic test_len_overflow();
    int w0;
    pulse_restart();
    w0 = wr_count;
    send_magic(1'b0);
    send_len(32'd65533, 1'b0);
    total_cnt++; if (error !== 2'd2) $display("FAIL ov_error: got %0h required 2", error); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL ov_ready: got %0h required 0", in_ready); else pass_cnt++;
    wait_cycles(2);
    total_cnt++; if (wr_count != w0) $display("FAIL ov_no_write: got %0d writes required 0", wr_count - w0); else pass_cnt++;
    pulse_restart();
    total_cnt++; if (error !== 2'd0) $display("FAIL ov_rs_error: got %0h required 0", error); else pass_cnt++;
    total_cnt++; if (state_dbg !== 3'd0) $display("FAIL ov_rs_state: got %0h required 0", state_dbg); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL ov_rs_ready: got %0h required 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_max_len();
    // exactly CAPACITY is legal: must go to LOAD, not ERROR
    send_magic(1'b0);
    send_len(32'd65532, 1'b0);
    total_cnt++; if (state_dbg !== 3'd2) $display("FAIL cap_state: got %0h required 2", state_dbg); else pass_cnt++;
    total_cnt++; if (error !== 2'd0) $display("FAIL cap_error: got %0h required 0", error); else pass_cnt++;
    pulse_restart();
  endtask

  task automatic test_zero_len();
    int w0;
    w0 = wr_count;
    send_magic(1'b0);
    send_len(32'd0, 1'b0);
    total_cnt++; if (state_dbg !== 3'd3) $display("FAIL z_state: got %0h required 3", state_dbg); else pass_cnt++;
    wait_cycles(1);
    total_cnt++; if (done !== 1'b1) $display("FAIL z_done: got %0h required 1", done); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b0) $display("FAIL z_cpu_reset: got %0h required 0", cpu_reset); else pass_cnt++;
    total_cnt++; if (loaded_len !== 32'd0) $display("FAIL z_loaded_len: got %0h required 0", loaded_len); else pass_cnt++;
    total_cnt++; if (wr_count != w0) $display("FAIL z_no_write: got %0d writes required 0", wr_count - w0); else pass_cnt++;
  endtask

  task automatic test_restart_priority();
    pulse_restart();
    send_magic(1'b0);
    restart = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    wait_cycles(1);
    restart = 1'b0; in_valid = 1'b0;
    total_cnt++; if (state_dbg !== 3'd0) $display("FAIL rp_state: got %0h required 0", state_dbg); else pass_cnt++;
    send_magic(1'b0);
    total_cnt++; if (state_dbg !== 3'd1) $display("FAIL rp_magic_again: got %0h required 1", state_dbg); else pass_cnt++;
    pulse_restart();
  endtask

  task automatic test_gaps();
    int w0;
    logic [7:0] pay[5];
    pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    w0 = wr_count;
    send_magic(1'b1);
    send_len(32'd5, 1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back({16'(4 + i), pay[i]});
    for (int i = 0; i < 5; i++) send_byte(pay[i], 1'b1);
    wait_cycles(3);
    total_cnt++; if (wr_count - w0 != 5) $display("FAIL gap_count: got %0d writes required 5", wr_count - w0); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL gap_sb_empty: got %0d pending required 0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL gap_done: got %0h required 1", done); else pass_cnt++;
    total_cnt++; if (loaded_len !== 32'd5) $display("FAIL gap_len: got %0h required 5", loaded_len); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    pulse_restart();
    send_magic(1'b0);
    send_len(32'd3, 1'b0);
    exp_q.push_back({16'd4, 8'hA1});
    exp_q.push_back({16'd5, 8'hA2});
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL ar_mem_we: got %0h required 0", mem_we); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'd4) $display("FAIL ar_mem_addr: got %0h required 4", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_data !== 8'd0) $display("FAIL ar_mem_data: got %0h required 0", mem_data); else pass_cnt++;
    total_cnt++; if (loaded_len !== 32'd0) $display("FAIL ar_loaded_len: got %0h required 0", loaded_len); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL ar_cpu_reset: got %0h required 1", cpu_reset); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL ar_ready: got %0h required 0", in_ready); else pass_cnt++;
    total_cnt++; if (state_dbg !== 3'd0) $display("FAIL ar_state: got %0h required 0", state_dbg); else pass_cnt++;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(1);
    send_magic(1'b0);
    send_len(32'd2, 1'b0);
    exp_q.push_back({16'd4, 8'h77});
    exp_q.push_back({16'd5, 8'h88});
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    wait_cycles(2);
    total_cnt++; if (done !== 1'b1) $display("FAIL ar_reload_done: got %0h required 1", done); else pass_cnt++;
    total_cnt++; if (loaded_len !== 32'd2) $display("FAIL ar_reload_len: got %0h required 2", loaded_len); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL ar_sb_empty: got %0d pending required 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; wr_count = 0; cyc = 0;
    test_reset();
    test_basic_load();
    test_restart_clears();
    test_bad_magic();
    test_len_overflow();
    test_max_len();
    test_zero_len();
    test_restart_priority();
    test_gaps();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
